// File: rtl/pipe_skid_chain_pkg.sv
// Shared types and constants for the pipe_skid_chain pipeline register chain.
package pipe_skid_chain_pkg;

    // Occupancy of one two-entry skid slice.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Width of the optional stall counter.
    localparam int PIPE_PERF_W = 32;

endpackage

// File: rtl/pipe_skid_chain_slice.sv
// pipe_skid_slice: one two-entry skid buffer slice with a valid/ready handshake.
// The main register drives the output directly and the skid register catches
// the one extra beat that arrives while downstream stalls. in_ready depends
// only on the slice state register, so out_ready never reaches in_ready
// combinationally.
module pipe_skid_slice
    import pipe_skid_chain_pkg::*;
#(
    parameter type T    = logic,
    parameter T    INIT = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_t state;
    T            main_data;
    T            skid_data;
    logic        in_xfer;
    logic        out_xfer;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Occupancy state machine moving payloads between input, main and skid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            main_data <= INIT;
            skid_data <= INIT;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data <= in_data;
                    end else if (in_xfer) begin
                        skid_data <= in_data;
                        state     <= TWO;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_data <= skid_data;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// pipe_skid_chain: DEPTH cascaded two-entry skid slices giving a valid/ready
// pipeline with full throughput, registered ready, and 2*DEPTH capacity.
// DEPTH = 0 degenerates to a combinational pass-through.
// Optional feature: define PIPE_SKID_PERF_EN to add the saturating stall_cnt
// output counting cycles with out_valid & ~out_ready.
module pipe_skid_chain
    import pipe_skid_chain_pkg::*;
#(
    parameter type T     = logic,
    parameter T    INIT  = '0,
    parameter int  DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [PIPE_PERF_W-1:0] stall_cnt
`endif
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;

            // Control inputs have no state to act on in pass-through mode.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset ^ flush;
        end else begin : g_chain
            logic vld [DEPTH+1];
            logic rdy [DEPTH+1];
            T     dat [DEPTH+1];

            assign vld[0]     = in_valid;
            assign dat[0]     = in_data;
            assign in_ready   = rdy[0];
            assign out_valid  = vld[DEPTH];
            assign out_data   = dat[DEPTH];
            assign rdy[DEPTH] = out_ready;

            for (genvar i = 0; i < DEPTH; i++) begin : g_slice
                pipe_skid_slice #(
                    .T    (T),
                    .INIT (INIT)
                ) u_slice (
                    .clk       (clk),
                    .reset     (reset),
                    .flush     (flush),
                    .in_valid  (vld[i]),
                    .in_ready  (rdy[i]),
                    .in_data   (dat[i]),
                    .out_valid (vld[i+1]),
                    .out_ready (rdy[i+1]),
                    .out_data  (dat[i+1])
                );
            end
        end
    endgenerate

`ifdef PIPE_SKID_PERF_EN
    function automatic logic [PIPE_PERF_W-1:0] sat_inc(input logic [PIPE_PERF_W-1:0] v);
        return (v == '1) ? v : v + PIPE_PERF_W'(1);
    endfunction

    // Count cycles where a valid payload is held off by downstream; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Self-checking bench for pipe_skid_chain: directed DEPTH=2 sequence plus a
// concurrent random handshake run on DEPTH 0, 1 and 3 instances.
module tb_pipe_skid_chain;

    typedef logic [15:0] data_t;
    localparam data_t INIT_V = 16'hC35A;
    localparam int    N_RND  = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  reset, flush, in_valid, in_ready, out_valid, out_ready;
    data_t in_data, out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cnt;
`endif

    pipe_skid_chain #(.T(data_t), .INIT(INIT_V), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    logic  r_in_valid [3];
    logic  r_in_ready [3];
    logic  r_out_valid [3];
    logic  r_out_ready [3];
    data_t r_in_data [3];
    data_t r_out_data [3];
`ifdef PIPE_SKID_PERF_EN
    logic [31:0] r_stall [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int D = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        pipe_skid_chain #(.T(data_t), .INIT(INIT_V), .DEPTH(D)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (r_in_valid[g]),
            .in_ready  (r_in_ready[g]),
            .in_data   (r_in_data[g]),
            .out_valid (r_out_valid[g]),
            .out_ready (r_out_ready[g]),
            .out_data  (r_out_data[g])
`ifdef PIPE_SKID_PERF_EN
            ,
            .stall_cnt (r_stall[g])
`endif
        );
    end

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_in, n_out, first_in, first_out, last_out, rdy_low, stall_model;
    data_t sbq [$];
    logic  hold_chk;
    data_t held;
    data_t rq [3][$];
    int    sent [3];
    int    got [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        n_in = 0; n_out = 0; first_in = -1; first_out = -1; last_out = -1; rdy_low = 0;
    endtask

    // One cycle on the DEPTH=2 instance: observe at negedge, update scoreboard, return at posedge+1.
    task automatic step();
        @(negedge clk);
        if (reset) begin
            stall_model = 0;
            hold_chk    = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(held));
            end
            if (!in_ready) rdy_low++;
            if (in_valid && in_ready && !flush) begin
                sbq.push_back(in_data);
                if (first_in < 0) first_in = cyc;
                n_in++;
            end
            if (out_valid && out_ready) begin
                total++;
                assert (sbq.size() != 0) else begin
                    bad++;
                    $error("FAIL underflow observed=%0h expected=none", out_data);
                end
                if (sbq.size() != 0) check("order", 32'(out_data), 32'(sbq.pop_front()));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
            if (out_valid && !out_ready) stall_model++;
            hold_chk = out_valid && !out_ready && !flush;
            held     = out_data;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r_in_valid[i] = 1'b0; r_in_data[i] = '0; r_out_ready[i] = 1'b0;
        end
        stall_model = 0; hold_chk = 1'b0; held = '0;
        reset_stats();

        // Reset held for three cycles.
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'(INIT_V));
`ifdef PIPE_SKID_PERF_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

        // Back-to-back stream 1..10 with downstream always ready.
        reset = 1'b0;
        reset_stats();
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (n_in < 10);
            in_data  = data_t'(n_in + 1);
            step();
        end
        in_valid = 1'b0;
        check("stream_count", 32'(n_out), 32'd10);
        check("stream_latency", 32'(first_out - first_in), 32'd2);
        check("stream_gapless", 32'(last_out - first_out), 32'd9);
        check("stream_ready_low", 32'(rdy_low), 32'd0);

        // Backpressure: fill to capacity, then drain.
        reset_stats();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (n_in < 6);
            in_data  = data_t'(n_in + 1);
            step();
        end
        check("bp_accepted", 32'(n_in), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_stall_model", 32'(stall_model), 32'd6);
`ifdef PIPE_SKID_PERF_EN
        check("bp_stall_cnt", stall_cnt, 32'(stall_model));
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (n_in < 6);
            in_data  = data_t'(n_in + 1);
            step();
        end
        in_valid = 1'b0;
        check("bp_drained", 32'(n_out), 32'd6);
        check("bp_gapless", 32'(last_out - first_out), 32'd5);
        check("bp_sb_empty", 32'(sbq.size()), 32'd0);

        // Flush at occupancy 3 with a payload offered in the flush cycle.
        reset_stats();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = data_t'(16'h11 * (c + 1));
            step();
        end
        check("fl_occupancy", 32'(n_in), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h00AA;
        step();
        flush = 1'b0; in_valid = 1'b0;
        sbq.delete();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_out_data", 32'(out_data), 32'(INIT_V));
`ifdef PIPE_SKID_PERF_EN
        check("fl_stall_kept", stall_cnt, 32'(stall_model));
`endif
        reset_stats();
        out_ready = 1'b1;
        repeat (6) step();
        check("fl_nothing_out", 32'(n_out), 32'd0);

        // Reset and flush together mid-stream.
        reset_stats();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = data_t'(16'h200 + c);
            step();
        end
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 16'h0BAD;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        sbq.delete();
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_in_ready", 32'(in_ready), 32'd1);
        check("rf_out_data", 32'(out_data), 32'(INIT_V));
`ifdef PIPE_SKID_PERF_EN
        check("rf_stall_cnt", stall_cnt, 32'd0);
`endif
        reset_stats();
        out_ready = 1'b1;
        repeat (4) step();
        check("rf_nothing_out", 32'(n_out), 32'd0);
        out_ready = 1'b0;

        // Random 50% valid / 50% ready on DEPTH 0, 1 and 3.
        for (int i = 0; i < 3; i++) begin
            sent[i] = 0; got[i] = 0;
        end
        for (int c = 0; c < 80000; c++) begin
            for (int i = 0; i < 3; i++) begin
                r_in_valid[i]  = (sent[i] < N_RND) && ($urandom_range(0, 1) == 1);
                r_in_data[i]   = data_t'(sent[i] + 1);
                r_out_ready[i] = ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (r_in_valid[i] && r_in_ready[i]) begin
                    rq[i].push_back(r_in_data[i]);
                    sent[i]++;
                end
                if (r_out_valid[i] && r_out_ready[i]) begin
                    total++;
                    assert (rq[i].size() != 0) else begin
                        bad++;
                        $error("FAIL rnd_underflow%0d observed=%0h expected=none", i, r_out_data[i]);
                    end
                    if (rq[i].size() != 0) check("rnd_order", 32'(r_out_data[i]), 32'(rq[i].pop_front()));
                    got[i]++;
                end
            end
            @(posedge clk);
            #1;
            if (got[0] >= N_RND && got[1] >= N_RND && got[2] >= N_RND) break;
        end
        for (int i = 0; i < 3; i++) begin
            r_in_valid[i] = 1'b0;
            check("rnd_count", 32'(got[i]), 32'(N_RND));
            check("rnd_leftover", 32'(rq[i].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
